ram_fifo_ctrl: RTL and testbench

- Sequencing controller that turns the team's simple dual-port RAM (one write port, one registered read port, read data 1 cycle after address) into a first-word-fall-through FIFO.
- Owns the write/read pointers, the occupancy count and the valid/ready handshakes.
- Drives the RAM's we, write_addr, data_in and read_addr, and takes its data_out back.
- Instantiated beside one RAM with matching DATA_WIDTH/ADDR_WIDTH; used as a stream buffer between producer and consumer in the same clock domain.

---
 rtl/ram_fifo_ctrl.sv | 73 +++++++
 tb/tb_ram_fifo_ctrl.sv | 117 +++++++++++
 2 files changed

// File: rtl/ram_fifo_ctrl.sv
// ram_fifo_ctrl: first-word-fall-through FIFO sequencer around a simple dual-port RAM with registered read.
// Define RAM_FIFO_ALMOST_FULL_EN to add the registered almost_full output (threshold AF_LEVEL).
module ram_fifo_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int AF_LEVEL   = 2**ADDR_WIDTH-2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [ADDR_WIDTH:0]   count,
`ifdef RAM_FIFO_ALMOST_FULL_EN
  output logic                  almost_full,
`endif
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_write_addr,
  output logic [DATA_WIDTH-1:0] ram_data_in,
  output logic [ADDR_WIDTH-1:0] ram_read_addr,
  input  logic [DATA_WIDTH-1:0] ram_data_out
);
  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] DEPTH = CW'(2**ADDR_WIDTH);
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d, avail_q, avail_d;
  logic push, pop, push_q;
  assign wr_ready = count_q != DEPTH;
  assign rd_valid = avail_q != '0;
  assign count = count_q;
  assign rd_data = ram_data_out;
  assign ram_we = push;
  assign ram_write_addr = wr_ptr_q;
  assign ram_data_in = wr_data;
  assign ram_read_addr = rd_ptr_q + ADDR_WIDTH'(pop);
  // avail trails count by the previous cycle's push so a word is never read in the cycle it is written
  always_comb begin
    push = wr_valid & wr_ready & ~rst;
    pop = rd_valid & rd_ready & ~rst;
    wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(push);
    rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(pop);
    count_d = count_q + CW'(push) - CW'(pop);
    avail_d = avail_q + CW'(push_q) - CW'(pop);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
      avail_q <= '0;
      push_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
      avail_q <= avail_d;
      push_q <= push;
    end
  end
`ifdef RAM_FIFO_ALMOST_FULL_EN
  logic almost_full_q;
  assign almost_full = almost_full_q;
  always_ff @(posedge clk) begin
    almost_full_q <= rst ? 1'b0 : (int'(count_d) >= AF_LEVEL);
  end
`else
  logic unused_af;
  assign unused_af = AF_LEVEL != 0;
`endif
endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// tb_ram_fifo_ctrl: directed and random stimulus against a queue-based FIFO model with an attached RAM model.
module tb_ram_fifo_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic wr_valid = 1'b0, rd_ready = 1'b0;
  logic [7:0] wr_data = '0;
  logic wr_ready, rd_valid, ram_we;
  logic [7:0] rd_data, ram_data_in, ram_data_out;
  logic [4:0] count;
  logic [3:0] ram_write_addr, ram_read_addr;
`ifdef RAM_FIFO_ALMOST_FULL_EN
  logic almost_full;
`endif
  logic [7:0] mem [16];
  int checks = 0, failures = 0;
  logic [7:0] q[$];
  bit last_push = 0;
  int pushes = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we) mem[ram_write_addr] <= ram_data_in;
    ram_data_out <= mem[ram_read_addr];
  end

  ram_fifo_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .AF_LEVEL(14)) dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .count(count),
`ifdef RAM_FIFO_ALMOST_FULL_EN
    .almost_full(almost_full),
`endif
    .ram_we(ram_we), .ram_write_addr(ram_write_addr), .ram_data_in(ram_data_in),
    .ram_read_addr(ram_read_addr), .ram_data_out(ram_data_out));

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // one clock: drive inputs, check against the model, advance the model
  task automatic cyc(input bit wv, input logic [7:0] wd, input bit rr);
    bit exp_valid, exp_push, exp_pop;
    wr_valid = wv; wr_data = wd; rd_ready = rr;
    #1;
    exp_valid = (q.size() - int'(last_push)) != 0;
    exp_push = wv && q.size() != 16;
    exp_pop = rr && exp_valid;
    chk("count", count, q.size());
    chk("wr_ready", wr_ready, q.size() != 16);
    chk("rd_valid", rd_valid, exp_valid);
    if (exp_valid) chk("rd_data", rd_data, q[0]);
    chk("ram_we", ram_we, exp_push);
    if (exp_push) chk("ram_write_addr", ram_write_addr, pushes % 16);
    if (exp_push) chk("ram_data_in", ram_data_in, wd);
`ifdef RAM_FIFO_ALMOST_FULL_EN
    chk("almost_full", almost_full, q.size() >= 14);
`endif
    @(posedge clk);
    #1;
    if (exp_pop) void'(q.pop_front());
    if (exp_push) begin q.push_back(wd); pushes++; end
    last_push = exp_push;
  endtask

  task automatic do_reset();
    rst = 1'b1; wr_valid = 1'b1; wr_data = 8'hEE; rd_ready = 1'b1;
    #1;
    chk("ram_we_in_rst", ram_we, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete(); last_push = 0; pushes = 0;
    chk("rst_count", count, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_wr_ready", wr_ready, 1);
  endtask

  initial begin
    @(posedge clk); #1;
    do_reset();
    for (int i = 0; i < 10; i++) cyc(0, 8'h00, 0);
    cyc(1, 8'hA5, 0);
    for (int i = 0; i < 7; i++) cyc(0, 8'h00, 0);
    cyc(0, 8'h00, 1);
    cyc(0, 8'h00, 0);
    for (int i = 0; i < 16; i++) cyc(1, 8'(i), 0);
    cyc(1, 8'h10, 0);
    chk("full_count", count, 16);
    for (int i = 0; i < 18; i++) cyc(0, 8'h00, 1);
    chk("drained", count, 0);
    for (int i = 0; i < 16; i++) cyc(1, 8'(i), 0);
    cyc(1, 8'h10, 1);
    chk("full_pop_only", count, 15);
    cyc(1, 8'h10, 0);
    for (int i = 0; i < 18; i++) cyc(0, 8'h00, 1);
    for (int i = 0; i < 40; i++) cyc(1, 8'(i), 1);
    for (int i = 0; i < 4; i++) cyc(0, 8'h00, 1);
    for (int i = 0; i < 400; i++) begin
      int mode;
      mode = i / 100;
      cyc($urandom_range(0, 3) < (mode == 1 ? 3 : 2), 8'($urandom), $urandom_range(0, 3) < (mode == 2 ? 3 : 2));
    end
    for (int i = 0; i < 20; i++) cyc(0, 8'h00, 1);
    for (int i = 0; i < 9; i++) cyc(i < 7, 8'h50 + 8'(i), 0);
    chk("pre_rst_count", count, 7);
    do_reset();
    cyc(1, 8'h3C, 0);
    for (int i = 0; i < 4; i++) cyc(0, 8'h00, 0);
    chk("post_rst_data", rd_data, 8'h3C);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
